// File: rtl/wishbone_pipeline_buffer_if.sv
// Wishbone pipelined-mode bus bundle shared by the buffer's upstream and downstream segments.
// The target modport is the view of a Target; the initiator modport is the view of an Initiator.
interface wishbone_pipeline_buffer_if #(
   parameter int unsigned AddressWidth = 16,
   parameter int unsigned DataWidth    = 8,
   parameter int unsigned Granularity  = 8,
   parameter int unsigned TGDWidth     = 1,
   parameter int unsigned TGAWidth     = 1,
   parameter int unsigned TGCWidth     = 1
);
   localparam int unsigned SelWidth = DataWidth / Granularity;

   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic                    lock;
   logic [AddressWidth-1:0] adr;
   logic [DataWidth-1:0]    dat_to_target;
   logic [SelWidth-1:0]     sel;
   logic [TGDWidth-1:0]     tgd_to_target;
   logic [TGAWidth-1:0]     tga;
   logic [TGCWidth-1:0]     tgc;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic                    stall;
   logic                    ack;
   logic                    err;
   logic                    rty;
   logic [DataWidth-1:0]    dat_to_initiator;
   logic [TGDWidth-1:0]     tgd_to_initiator;

   modport target (
      input  cyc, stb, we, lock, adr, dat_to_target, sel, tgd_to_target, tga, tgc, cti, bte,
      output stall, ack, err, rty, dat_to_initiator, tgd_to_initiator
   );

   modport initiator (
      output cyc, stb, we, lock, adr, dat_to_target, sel, tgd_to_target, tga, tgc, cti, bte,
      input  stall, ack, err, rty, dat_to_initiator, tgd_to_initiator
   );
endinterface

// File: rtl/wishbone_pipeline_buffer.sv
// Same-clock Wishbone pipelined buffer: request and response FIFOs between an Initiator and a
// Target, outstanding-count based STALL, and a clean flush when the Initiator drops CYC early.
module wishbone_pipeline_buffer #(
   parameter int unsigned AddressWidth = 16,
   parameter int unsigned DataWidth    = 8,
   parameter int unsigned Granularity  = 8,
   parameter int unsigned TGDWidth     = 1,
   parameter int unsigned TGAWidth     = 1,
   parameter int unsigned TGCWidth     = 1,
   parameter int unsigned Depth        = 4,
   parameter bit          LOWPOWER     = 1'b1,
   parameter bit          STRICT       = 1'b0
) (
   input logic                           i_clk,
   input logic                           i_rst,
   wishbone_pipeline_buffer_if.target    io_initiator,
   wishbone_pipeline_buffer_if.initiator io_target
);
   localparam int unsigned SelWidth = DataWidth / Granularity;
   localparam int unsigned PtrWidth = $clog2(Depth);
   localparam int unsigned ReqWidth = 1 + AddressWidth + DataWidth + SelWidth + TGDWidth +
                                      TGAWidth + TGCWidth + 3 + 2;
   localparam int unsigned RspWidth = 3 + DataWidth + TGDWidth;
   localparam logic [PtrWidth:0] PtrOne = (PtrWidth + 1)'(1);
   localparam logic [PtrWidth:0] OutMax = (PtrWidth + 1)'(Depth);

   logic [ReqWidth-1:0] r_req_mem [Depth];
   logic                r_lock_mem [Depth];
   logic [RspWidth-1:0] r_rsp_mem [Depth];
   logic [PtrWidth:0]   r_req_wr;
   logic [PtrWidth:0]   r_req_rd;
   logic [PtrWidth:0]   r_rsp_wr;
   logic [PtrWidth:0]   r_rsp_rd;
   logic [PtrWidth:0]   r_out;
   logic                r_abort;
   logic                r_tgt_cyc;
   logic                r_tgt_lock;
   logic [ReqWidth-1:0] r_tgt_hold;
   logic [DataWidth-1:0] r_dat_hold;
   logic [TGDWidth-1:0]  r_tgd_hold;

   logic [ReqWidth-1:0] w_req_in;
   logic [ReqWidth-1:0] w_req_head;
   logic [ReqWidth-1:0] w_tgt_out;
   logic [RspWidth-1:0] w_rsp_in;
   logic [RspWidth-1:0] w_rsp_head;
   logic                w_req_empty;
   logic                w_rsp_empty;
   logic                w_rsp_full;
   logic                w_stall;
   logic                w_accept;
   logic                w_abort;
   logic                w_tgt_stb;
   logic                w_tgt_pop;
   logic                w_rsp_any;
   logic                w_rsp_ok;
   logic                w_rsp_push;
   logic                w_deliver;
   logic                w_h_ack;
   logic                w_h_err;
   logic                w_h_rty;
   logic [DataWidth-1:0] w_h_dat;
   logic [TGDWidth-1:0]  w_h_tgd;
   logic [PtrWidth:0]    w_out_d;

   assign w_req_empty = (r_req_wr == r_req_rd);
   assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);
   assign w_rsp_full  = (r_rsp_wr[PtrWidth] != r_rsp_rd[PtrWidth]) &&
                        (r_rsp_wr[PtrWidth-1:0] == r_rsp_rd[PtrWidth-1:0]);

   // Capping Out at Depth means neither FIFO can overflow, so the Target needs no back-pressure.
   assign w_stall  = (r_out == OutMax) | r_abort;
   assign w_accept = io_initiator.cyc & io_initiator.stb & ~w_stall;
   assign w_abort  = ~io_initiator.cyc & (r_out != '0);

   assign w_req_in = {io_initiator.we, io_initiator.adr, io_initiator.dat_to_target,
                      io_initiator.sel, io_initiator.tgd_to_target, io_initiator.tga,
                      io_initiator.tgc, io_initiator.cti, io_initiator.bte};
   assign w_req_head = r_req_mem[r_req_rd[PtrWidth-1:0]];

   assign w_tgt_stb = ~w_req_empty & r_tgt_cyc;
   assign w_tgt_pop = w_tgt_stb & ~io_target.stall;
   assign w_tgt_out = (LOWPOWER && !w_tgt_stb) ? r_tgt_hold : w_req_head;

   assign io_target.cyc  = r_tgt_cyc;
   assign io_target.stb  = w_tgt_stb;
   assign io_target.lock = r_tgt_lock;
   assign {io_target.we, io_target.adr, io_target.dat_to_target, io_target.sel,
           io_target.tgd_to_target, io_target.tga, io_target.tgc, io_target.cti,
           io_target.bte} = w_tgt_out;

   assign w_rsp_any  = io_target.ack | io_target.err | io_target.rty;
   assign w_rsp_ok   = STRICT ? w_rsp_any : (w_rsp_any & r_tgt_cyc & (r_out != '0));
   assign w_rsp_push = w_rsp_ok & ~w_rsp_full & ~w_abort;
   assign w_rsp_in   = {io_target.ack, io_target.err, io_target.rty, io_target.dat_to_initiator,
                        io_target.tgd_to_initiator};
   assign w_rsp_head = r_rsp_mem[r_rsp_rd[PtrWidth-1:0]];
   assign {w_h_ack, w_h_err, w_h_rty, w_h_dat, w_h_tgd} = w_rsp_head;

   // The response head is shown straight from the FIFO flops; it is popped in the same cycle.
   assign w_deliver = ~w_rsp_empty;
   assign io_initiator.stall            = w_stall;
   assign io_initiator.ack              = w_deliver & w_h_ack;
   assign io_initiator.err              = w_deliver & w_h_err;
   assign io_initiator.rty              = w_deliver & w_h_rty;
   assign io_initiator.dat_to_initiator = w_deliver ? w_h_dat : r_dat_hold;
   assign io_initiator.tgd_to_initiator = w_deliver ? w_h_tgd : r_tgd_hold;

   always_comb begin
      w_out_d = r_out;
      if (w_accept) begin
         w_out_d = w_out_d + PtrOne;
      end
      if (w_deliver && (r_out != '0)) begin
         w_out_d = w_out_d - PtrOne;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_req_mem  <= '{default: '0};
         r_lock_mem <= '{default: 1'b0};
         r_rsp_mem  <= '{default: '0};
         r_req_wr   <= '0;
         r_req_rd   <= '0;
         r_rsp_wr   <= '0;
         r_rsp_rd   <= '0;
         r_out      <= '0;
         r_abort    <= 1'b0;
         r_tgt_cyc  <= 1'b0;
         r_tgt_lock <= 1'b0;
         r_tgt_hold <= '0;
         r_dat_hold <= '0;
         r_tgd_hold <= '0;
      end else begin
         r_abort   <= w_abort;
         r_tgt_cyc <= io_initiator.cyc;
         if (w_tgt_stb) begin
            r_tgt_hold <= w_req_head;
         end
         if (w_tgt_pop) begin
            r_tgt_lock <= r_lock_mem[r_req_rd[PtrWidth-1:0]];
         end
         if (w_deliver) begin
            r_dat_hold <= w_h_dat;
            r_tgd_hold <= w_h_tgd;
         end
         if (w_accept) begin
            r_req_mem[r_req_wr[PtrWidth-1:0]]  <= w_req_in;
            r_lock_mem[r_req_wr[PtrWidth-1:0]] <= io_initiator.lock;
         end
         if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wr[PtrWidth-1:0]] <= w_rsp_in;
         end
         // Flushing moves read pointers onto write pointers so indices keep running after abort.
         if (w_abort) begin
            r_req_rd <= r_req_wr;
            r_rsp_rd <= r_rsp_wr;
            r_out    <= '0;
         end else begin
            if (w_accept) begin
               r_req_wr <= r_req_wr + PtrOne;
            end
            if (w_tgt_pop) begin
               r_req_rd <= r_req_rd + PtrOne;
            end
            if (w_rsp_push) begin
               r_rsp_wr <= r_rsp_wr + PtrOne;
            end
            if (w_deliver) begin
               r_rsp_rd <= r_rsp_rd + PtrOne;
            end
            r_out <= w_out_d;
         end
      end
   end
endmodule
